// File: rtl/fetch_stage.sv
// Instruction-fetch front end: fetch PC, single-outstanding imem handshake,
// 2-entry instruction queue toward decode, redirect handling with wrong-path drop.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [5:0]  id_op,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_addr;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_addr_nxt;

  logic [1:0]  r_count;
  logic        r_head;
  logic [31:0] r_q_instr [2];
  logic [31:0] r_q_pc    [2];

  logic        w_pop;
  logic        w_ack;
  logic        w_push;
  logic        w_room;
  logic [2:0]  w_occ;
  logic        w_wr_idx;

  // Occupancy after this edge decides whether another request may be issued.
  always_comb begin
    w_pop    = (r_count != 2'd0) && id_ready;
    w_ack    = imem_ack && (r_state != S_IDLE);
    w_push   = (r_state == S_WAIT) && w_ack && !redirect_valid;
    w_occ    = {1'b0, r_count} + {2'b00, w_push} - {2'b00, w_pop};
    w_room   = (w_occ <= 3'd1);
    w_wr_idx = r_head ^ r_count[0];
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (redirect_valid) begin
          w_addr_nxt  = redirect_pc;
          w_pc_nxt    = redirect_pc + 32'd4;
          w_state_nxt = S_WAIT;
        end else if (w_room) begin
          w_addr_nxt  = r_pc;
          w_pc_nxt    = r_pc + 32'd4;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_ack) begin
          if (redirect_valid) begin
            w_addr_nxt  = redirect_pc;
            w_pc_nxt    = redirect_pc + 32'd4;
            w_state_nxt = S_WAIT;
          end else if (w_room) begin
            w_addr_nxt  = r_pc;
            w_pc_nxt    = r_pc + 32'd4;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (redirect_valid) begin
          // Request stays pending on the old address; its data is dropped later.
          w_pc_nxt    = redirect_pc;
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (w_ack) begin
          if (redirect_valid) begin
            w_addr_nxt = redirect_pc;
            w_pc_nxt   = redirect_pc + 32'd4;
          end else begin
            w_addr_nxt = r_pc;
            w_pc_nxt   = r_pc + 32'd4;
          end
          w_state_nxt = S_WAIT;
        end else if (redirect_valid) begin
          w_pc_nxt = redirect_pc;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (redirect_valid) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
    end else begin
      if (w_push) begin
        r_q_instr[w_wr_idx] <= imem_rdata;
        r_q_pc[w_wr_idx]    <= r_addr;
      end
      r_count <= w_occ[1:0];
      if (w_pop) begin
        r_head <= ~r_head;
      end
    end
  end

  always_comb begin
    imem_req    = (r_state != S_IDLE);
    imem_addr   = r_addr;
    id_valid    = (r_count != 2'd0);
    id_instr    = id_valid ? r_q_instr[r_head] : '0;
    id_pc       = id_valid ? r_q_pc[r_head] : '0;
    id_pc_plus4 = id_valid ? (r_q_pc[r_head] + 32'd4) : '0;
    id_op       = id_instr[31:26];
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed cycle tables, async-reset sequence, and a
// randomized run scored against an in-order delivered-PC reference.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [5:0]  id_op;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr),
    .id_op(id_op), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[7:2] ^ 6'h15, a[27:2]};
  endfunction

  assign imem_rdata = memf(imem_addr);

  typedef struct {
    logic        rst_before;
    logic        ack;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic rb, logic ack, logic rdy, logic rd, logic [31:0] rpc,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ep);
    vec_t v;
    v.rst_before = rb; v.ack = ack; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_out(input string nm, input int idx, input logic e_req,
                           input logic [31:0] e_addr, input logic e_valid, input logic [31:0] e_pc);
    logic [31:0] e_instr;
    logic [31:0] e_p4;
    logic [5:0]  e_op;
    e_instr = e_valid ? memf(e_pc) : 32'h0;
    e_p4    = e_valid ? e_pc + 32'd4 : 32'h0;
    e_op    = e_instr[31:26];
    n_tests++;
    if (imem_req !== e_req || imem_addr !== e_addr || id_valid !== e_valid ||
        id_pc !== e_pc || id_instr !== e_instr || id_pc_plus4 !== e_p4 || id_op !== e_op) begin
      n_fail++;
      $display("FAIL %s[%0d]: got req=%b addr=%h v=%b pc=%h instr=%h p4=%h op=%h; want req=%b addr=%h v=%b pc=%h instr=%h p4=%h op=%h",
               nm, idx, imem_req, imem_addr, id_valid, id_pc, id_instr, id_pc_plus4, id_op,
               e_req, e_addr, e_valid, e_pc, e_instr, e_p4, e_op);
    end
  endtask

  task automatic run_vec(input string nm, input int idx, input vec_t v);
    if (v.rst_before) do_reset();
    imem_ack = v.ack; id_ready = v.rdy; redirect_valid = v.redir; redirect_pc = v.rpc;
    check_out(nm, idx, v.e_req, v.e_addr, v.e_valid, v.e_pc);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_pc;
  int          lat;
  int          stall;
  logic        prev_hold;
  logic        prev_redir;
  logic [31:0] prev_addr;

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

    // zero-wait memory, decode always ready
    vt.push_back(mk(1,0,1,0,0,           0,0,0,0));
    vt.push_back(mk(0,1,1,0,0,           1,0,0,0));
    vt.push_back(mk(0,1,1,0,0,           1,4,1,0));
    vt.push_back(mk(0,1,1,0,0,           1,8,1,4));
    vt.push_back(mk(0,1,1,0,0,           1,12,1,8));
    vt.push_back(mk(0,1,1,0,0,           1,16,1,12));
    // backpressure: two pushes then idle until a pop
    vt.push_back(mk(1,0,0,0,0,           0,0,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,0,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,4,1,0));
    vt.push_back(mk(0,0,0,0,0,           0,4,1,0));
    vt.push_back(mk(0,0,0,0,0,           0,4,1,0));
    vt.push_back(mk(0,0,1,0,0,           0,4,1,0));
    vt.push_back(mk(0,1,1,0,0,           1,8,1,4));
    vt.push_back(mk(0,0,1,0,0,           1,12,1,8));
    vt.push_back(mk(0,0,0,0,0,           1,12,0,0));
    // redirect while waiting: old request held until ack, word dropped
    vt.push_back(mk(1,0,1,0,0,           0,0,0,0));
    vt.push_back(mk(0,0,1,1,32'h40,      1,0,0,0));
    vt.push_back(mk(0,0,1,0,0,           1,0,0,0));
    vt.push_back(mk(0,1,1,0,0,           1,0,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,32'h40,0,0));
    vt.push_back(mk(0,0,0,0,0,           1,32'h44,1,32'h40));
    // redirect in an ack cycle with a queued entry
    vt.push_back(mk(1,0,0,0,0,           0,0,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,0,0,0));
    vt.push_back(mk(0,1,0,1,32'h80,      1,4,1,0));
    vt.push_back(mk(0,0,0,0,0,           1,32'h80,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,32'h80,0,0));
    vt.push_back(mk(0,0,0,0,0,           1,32'h84,1,32'h80));
    // two redirects during the drop: latest wins
    vt.push_back(mk(1,0,1,0,0,           0,0,0,0));
    vt.push_back(mk(0,0,1,1,32'h100,     1,0,0,0));
    vt.push_back(mk(0,0,1,1,32'h200,     1,0,0,0));
    vt.push_back(mk(0,0,1,0,0,           1,0,0,0));
    vt.push_back(mk(0,1,1,0,0,           1,0,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,32'h200,0,0));
    vt.push_back(mk(0,0,0,0,0,           1,32'h204,1,32'h200));
    // redirect coinciding with the dropped ack
    vt.push_back(mk(1,0,1,0,0,           0,0,0,0));
    vt.push_back(mk(0,0,1,1,32'h100,     1,0,0,0));
    vt.push_back(mk(0,1,1,1,32'h300,     1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,           1,32'h300,0,0));
    // redirect from idle with full queue, wrap of PC arithmetic
    vt.push_back(mk(1,0,0,0,0,           0,0,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,0,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,4,1,0));
    vt.push_back(mk(0,0,0,1,32'hFFFF_FFFC, 0,4,1,0));
    vt.push_back(mk(0,1,0,0,0,           1,32'hFFFF_FFFC,0,0));
    vt.push_back(mk(0,1,1,0,0,           1,0,1,32'hFFFF_FFFC));
    vt.push_back(mk(0,0,0,0,0,           1,4,1,0));
    // setup for async reset: WAIT with one queued entry
    vt.push_back(mk(1,0,0,0,0,           0,0,0,0));
    vt.push_back(mk(0,1,0,0,0,           1,0,0,0));
    vt.push_back(mk(0,0,0,0,0,           1,4,1,0));

    foreach (vt[i]) run_vec("vec", i, vt[i]);

    // async reset mid-request, then a late ack must be ignored
    rst = 1'b1;
    #1;
    check_out("async_rst", 0, 1'b0, RPC, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0; imem_ack = 1'b1; id_ready = 1'b0;
    check_out("late_ack", 0, 1'b0, RPC, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check_out("late_ack", 1, 1'b1, RPC, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    imem_ack = 1'b1;
    check_out("late_ack", 2, 1'b1, RPC, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    imem_ack = 1'b0;
    check_out("late_ack", 3, 1'b1, RPC + 32'd4, 1'b1, RPC);

    // randomized run against in-order delivered-PC reference
    do_reset();
    exp_pc = RPC; lat = 0; stall = 0;
    prev_hold = 1'b0; prev_redir = 1'b0; prev_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_hold) begin
        n_tests++;
        if (!(imem_req === 1'b1 && imem_addr === prev_addr)) begin
          n_fail++;
          $display("FAIL req_hold cyc %0d: got req=%b addr=%h, want req=1 addr=%h",
                   cyc, imem_req, imem_addr, prev_addr);
        end
      end
      if (prev_redir) begin
        n_tests++;
        if (id_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL flush cyc %0d: got id_valid=%b, want 0", cyc, id_valid);
        end
      end
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      if (imem_req) begin
        if (lat == 0) begin
          imem_ack = 1'b1;
          lat = $urandom_range(0, 3);
        end else begin
          imem_ack = 1'b0;
          lat--;
        end
      end else begin
        imem_ack = $urandom_range(0, 1) != 0;
      end
      #1;
      if (id_valid && id_ready) begin
        n_tests++;
        if (id_pc !== exp_pc || id_instr !== memf(exp_pc) ||
            id_pc_plus4 !== exp_pc + 32'd4 || id_op !== id_instr[31:26]) begin
          n_fail++;
          $display("FAIL deliver cyc %0d: got pc=%h instr=%h p4=%h op=%h, want pc=%h instr=%h p4=%h",
                   cyc, id_pc, id_instr, id_pc_plus4, id_op, exp_pc, memf(exp_pc), exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
        stall = 0;
      end else if (id_ready) begin
        stall++;
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        stall = 0;
      end
      if (stall > 30) begin
        n_tests++;
        n_fail++;
        $display("FAIL progress cyc %0d: got no delivery in %0d ready cycles, want <= 30", cyc, stall);
        stall = 0;
      end
      prev_hold  = imem_req && !imem_ack;
      prev_addr  = imem_addr;
      prev_redir = redirect_valid;
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
